alu_bist: RTL and testbench

Built-in self-test driver and checker for the RV32 integer ALU. It sits beside the ALU in the datapath and is muxed onto the ALU operand and control inputs in test mode. It generates operand/control vectors for every ALU operation, captures the ALU's Result/Zero, and compares them against an internal golden model. It accumulates a pass/fail verdict plus first-failure diagnostics.

---
 rtl/alu_pkg.sv | 32 +++
 rtl/alu_golden.sv | 35 +++
 rtl/alu_bist.sv | 139 +++++++++++++
 tb/tb_alu_bist.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation codes, op count, BIST LFSR mask and FSM states.
// Used by the ALU, its golden model and the BIST driver.
package alu_pkg;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_AND = 4'b0010;
    localparam logic [3:0] ALU_OR  = 4'b0011;
    localparam logic [3:0] ALU_XOR = 4'b0100;
    localparam logic [3:0] ALU_SLL = 4'b0101;
    localparam logic [3:0] ALU_SRL = 4'b0110;
    localparam logic [3:0] ALU_SRA = 4'b0111;
    localparam logic [3:0] ALU_SLT = 4'b1000;

    localparam int ALU_NUM_OPS = 9;

    localparam logic [31:0] LFSR_MASK = 32'h8020_0003;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DRIVE,
        ST_SETTLE,
        ST_CHECK,
        ST_DONE
    } bist_state_e;

    // One step of the right-shifting Galois LFSR.
    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        return (s >> 1) ^ (s[0] ? LFSR_MASK : 32'h0);
    endfunction

endpackage

// File: rtl/alu_golden.sv
// Combinational reference ALU used by the BIST to compute the expected Result.
// Codes outside ADD..SLT produce zero.
module alu_golden (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [3:0]  ctrl,
    output logic [31:0] result
);
    import alu_pkg::*;

    logic signed [31:0] a_s;
    logic signed [31:0] b_s;
    logic        [4:0]  shamt;

    assign a_s   = a;
    assign b_s   = b;
    assign shamt = b[4:0];

    always_comb begin
        result = 32'h0;
        case (ctrl)
            ALU_ADD: result = a + b;
            ALU_SUB: result = a - b;
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_XOR: result = a ^ b;
            ALU_SLL: result = a << shamt;
            ALU_SRL: result = a >> shamt;
            ALU_SRA: result = a_s >>> shamt;
            ALU_SLT: result = {31'b0, (a_s < b_s)};
            default: result = 32'h0;
        endcase
    end

endmodule

// File: rtl/alu_bist.sv
// BIST driver/checker for the RV32 ALU: walks every op with fixed and LFSR vectors,
// compares the ALU against alu_golden and keeps a verdict with first-failure info.
module alu_bist #(
    parameter int          NUM_VECTORS   = 16,
    parameter int          SETTLE_CYCLES = 1,
    parameter logic [31:0] LFSR_SEED     = 32'hACE1_2468
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [3:0]  alu_ctrl,
    input  logic [31:0] alu_result,
    input  logic        alu_zero,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [15:0] err_count,
    output logic [3:0]  first_fail_ctrl,
    output logic [15:0] first_fail_idx
);
    import alu_pkg::*;

    localparam logic [31:0] SEED        = (LFSR_SEED == 32'h0) ? 32'h1 : LFSR_SEED;
    localparam logic [15:0] VEC_LAST    = 16'(NUM_VECTORS - 1);
    localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYCLES - 1);
    localparam logic [3:0]  OP_LAST     = 4'(ALU_NUM_OPS - 1);

    bist_state_e state;
    bist_state_e state_nxt;

    logic [3:0]  op;
    logic [15:0] vec;
    logic [15:0] gidx;
    logic [15:0] settle_cnt;
    logic [31:0] lfsr;
    logic [31:0] exp_result;
    logic        exp_zero;
    logic        mismatch;

    alu_golden u_golden (
        .a      (alu_a),
        .b      (alu_b),
        .ctrl   (alu_ctrl),
        .result (exp_result)
    );

    assign exp_zero = (exp_result == 32'h0);
    assign mismatch = (alu_result != exp_result) || (alu_zero != exp_zero);
    assign pass     = (err_count == 16'h0);

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (start) state_nxt = ST_DRIVE;
            ST_DRIVE:  state_nxt = ST_SETTLE;
            ST_SETTLE: if (settle_cnt == SETTLE_LAST) state_nxt = ST_CHECK;
            ST_CHECK:  state_nxt = (vec == VEC_LAST && op == OP_LAST) ? ST_DONE : ST_DRIVE;
            ST_DONE:   state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= ST_IDLE;
            op              <= 4'h0;
            vec             <= 16'h0;
            gidx            <= 16'h0;
            settle_cnt      <= 16'h0;
            lfsr            <= SEED;
            alu_a           <= 32'h0;
            alu_b           <= 32'h0;
            alu_ctrl        <= 4'h0;
            busy            <= 1'b0;
            done            <= 1'b0;
            err_count       <= 16'h0;
            first_fail_ctrl <= 4'h0;
            first_fail_idx  <= 16'h0;
        end else begin
            state <= state_nxt;
            done  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        op              <= 4'h0;
                        vec             <= 16'h0;
                        gidx            <= 16'h0;
                        lfsr            <= SEED;
                        busy            <= 1'b1;
                        err_count       <= 16'h0;
                        first_fail_ctrl <= 4'h0;
                        first_fail_idx  <= 16'h0;
                    end
                end
                ST_DRIVE: begin
                    settle_cnt <= 16'h0;
                    alu_ctrl   <= op;
                    if (vec == 16'd0) begin
                        alu_a <= 32'h0;
                        alu_b <= 32'h0;
                    end else if (vec == 16'd1) begin
                        alu_a <= 32'h8000_0000;
                        alu_b <= 32'h0000_001F;
                    end else begin
                        alu_a <= lfsr;
                        alu_b <= {lfsr[15:0], lfsr[31:16]};
                        lfsr  <= lfsr_next(lfsr);
                    end
                end
                ST_SETTLE: settle_cnt <= settle_cnt + 16'd1;
                ST_CHECK: begin
                    if (mismatch) begin
                        if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
                        if (err_count == 16'h0) begin
                            first_fail_ctrl <= alu_ctrl;
                            first_fail_idx  <= gidx;
                        end
                    end
                    gidx <= gidx + 16'd1;
                    if (vec == VEC_LAST) begin
                        vec <= 16'h0;
                        op  <= op + 4'd1;
                    end else begin
                        vec <= vec + 16'd1;
                    end
                end
                // done is registered, so it rises one cycle after DONE, as busy falls.
                ST_DONE: begin
                    done <= 1'b1;
                    busy <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_bist.sv
// Bench for alu_bist: a fault-injectable ALU beside the DUT, and a reference model that
// derives vector sequences and verdicts directly from the ALU/LFSR rules.
module tb_alu_bist;
    localparam int          NV      = 4;
    localparam int          SC      = 1;
    localparam int          NVEC    = 9 * NV;
    localparam int          RUN_CYC = NVEC * (SC + 2) + 1;
    localparam logic [31:0] SEED    = 32'hACE1_2468;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] alu_a, alu_b, alu_result;
    logic [3:0]  alu_ctrl;
    logic        alu_zero, busy, done, pass;
    logic [15:0] err_count, first_fail_idx;
    logic [3:0]  first_fail_ctrl;

    int          errors = 0;
    int          checks = 0;
    int          fault_mode = 0;
    logic [3:0]  f_op = 4'h0;
    logic [4:0]  f_bit = 5'h0;

    logic [31:0] m_a [NVEC];
    logic [31:0] m_b [NVEC];
    logic [31:0] obs_a [NVEC];
    logic [31:0] obs_b [NVEC];
    logic [3:0]  obs_c [NVEC];
    logic [31:0] prev_a [NVEC];
    logic [31:0] prev_b [NVEC];

    always #5 clk = ~clk;

    alu_bist #(.NUM_VECTORS(NV), .SETTLE_CYCLES(SC), .LFSR_SEED(SEED)) dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .alu_a           (alu_a),
        .alu_b           (alu_b),
        .alu_ctrl        (alu_ctrl),
        .alu_result      (alu_result),
        .alu_zero        (alu_zero),
        .busy            (busy),
        .done            (done),
        .pass            (pass),
        .err_count       (err_count),
        .first_fail_ctrl (first_fail_ctrl),
        .first_fail_idx  (first_fail_idx)
    );

    function automatic logic [31:0] ref_alu(input int op, input logic [31:0] a, input logic [31:0] b);
        int s;
        s = int'(b[4:0]);
        case (op)
            0: return a + b;
            1: return a + ~b + 32'd1;
            2: return a & b;
            3: return a | b;
            4: return a ^ b;
            5: return a << s;
            6: return a >> s;
            7: return (a >> s) | (a[31] ? ~(32'hFFFF_FFFF >> s) : 32'h0);
            8: return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
            default: return 32'h0;
        endcase
    endfunction

    // ALU under test: correct, or with one planted fault selected by mode.
    function automatic logic [32:0] env_alu(input int mode, input logic [3:0] ctrl,
                                            input logic [31:0] a, input logic [31:0] b,
                                            input logic [3:0] fop, input logic [4:0] fbit);
        logic [31:0] r;
        logic        z;
        r = ref_alu(int'(ctrl), a, b);
        if (mode == 1 && ctrl == 4'd7) r = a >> b[4:0];
        if (mode == 3 && ctrl == fop) r = r ^ (32'h1 << fbit);
        z = (r == 32'h0) && (mode != 2);
        return {z, r};
    endfunction

    always_comb {alu_zero, alu_result} = env_alu(fault_mode, alu_ctrl, alu_a, alu_b, f_op, f_bit);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic build_vectors();
        logic [31:0] x;
        x = SEED;
        for (int g = 0; g < NVEC; g++) begin
            case (g % NV)
                0: begin m_a[g] = 32'h0; m_b[g] = 32'h0; end
                1: begin m_a[g] = 32'h8000_0000; m_b[g] = 32'h1F; end
                default: begin
                    m_a[g] = x;
                    m_b[g] = {x[15:0], x[31:16]};
                    x = x[0] ? ((x >> 1) ^ 32'h8020_0003) : (x >> 1);
                end
            endcase
        end
    endtask

    task automatic model_verdict(input int mode, output int e_err, output int e_fidx, output int e_fctrl);
        logic [31:0] want;
        logic [32:0] got;
        e_err = 0; e_fidx = 0; e_fctrl = 0;
        for (int g = 0; g < NVEC; g++) begin
            want = ref_alu(g / NV, m_a[g], m_b[g]);
            got  = env_alu(mode, 4'(g / NV), m_a[g], m_b[g], f_op, f_bit);
            if (got != {(want == 32'h0), want}) begin
                if (e_err == 0) begin e_fidx = g; e_fctrl = g / NV; end
                e_err++;
            end
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_pass"}, 32'(pass), 32'd1);
        check({tag, "_err"}, 32'(err_count), 32'd0);
        check({tag, "_ffidx"}, 32'(first_fail_idx), 32'd0);
        check({tag, "_ffctrl"}, 32'(first_fail_ctrl), 32'd0);
        check({tag, "_ops"}, alu_a | alu_b | 32'(alu_ctrl), 32'd0);
    endtask

    task automatic do_run(input string tag, input int mode, input bit hold_start);
        int e_err, e_fidx, e_fctrl, done_cnt, done_at, bad;
        model_verdict(mode, e_err, e_fidx, e_fctrl);
        fault_mode = mode;
        start = 1'b1;
        @(posedge clk); #1;
        if (!hold_start) start = 1'b0;
        check({tag, "_busy_start"}, 32'(busy), 32'd1);
        done_cnt = 0; done_at = -1;
        for (int c = 1; c <= RUN_CYC + 1; c++) begin
            @(posedge clk); #1;
            if (c % (SC + 2) == 2 && c / (SC + 2) < NVEC) begin
                obs_a[c / (SC + 2)] = alu_a;
                obs_b[c / (SC + 2)] = alu_b;
                obs_c[c / (SC + 2)] = alu_ctrl;
            end
            if (done) begin
                done_cnt++;
                if (done_at < 0) done_at = c;
            end
            if (c == RUN_CYC) begin
                check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
                check({tag, "_pass"}, 32'(pass), 32'(e_err == 0));
                check({tag, "_err"}, 32'(err_count), 32'(e_err));
                check({tag, "_ffidx"}, 32'(first_fail_idx), 32'(e_fidx));
                check({tag, "_ffctrl"}, 32'(first_fail_ctrl), 32'(e_fctrl));
            end
        end
        check({tag, "_done_cycle"}, 32'(done_at), 32'(RUN_CYC));
        check({tag, "_done_count"}, 32'(done_cnt), 32'd1);
        check({tag, "_busy_after"}, 32'(busy), 32'(hold_start));
        bad = 0;
        for (int g = 0; g < NVEC; g++)
            if (obs_a[g] !== m_a[g] || obs_b[g] !== m_b[g] || obs_c[g] !== 4'(g / NV)) bad++;
        check({tag, "_operand_seq_bad"}, 32'(bad), 32'd0);
    endtask

    initial begin
        int rc, dc, bad;
        build_vectors();
        rst = 1'b1; start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_idle("reset");
        rst = 1'b0;
        repeat ($urandom_range(1, 4)) @(posedge clk);
        #1;

        do_run("run_ok1", 0, 1'b0);
        for (int g = 0; g < NVEC; g++) begin prev_a[g] = obs_a[g]; prev_b[g] = obs_b[g]; end
        repeat ($urandom_range(0, 5)) @(posedge clk);
        #1;
        do_run("run_ok2", 0, 1'b0);
        bad = 0;
        for (int g = 0; g < NVEC; g++)
            if (obs_a[g] !== prev_a[g] || obs_b[g] !== prev_b[g]) bad++;
        check("repeat_run_diff", 32'(bad), 32'd0);

        do_run("sra_fault", 1, 1'b0);
        check("sra_ffctrl_const", 32'(first_fail_ctrl), 32'd7);
        check("sra_ffidx_const", 32'(first_fail_idx), 32'(7 * NV + 1));

        do_run("zero_fault", 2, 1'b0);
        check("zero_ffidx_const", 32'(first_fail_idx), 32'd0);

        // Reset in the middle of vector 5 of a failing run.
        fault_mode = 2;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        rc = 5 * (SC + 2) + 1 + int'($urandom_range(0, SC + 1));
        for (int c = 1; c <= rc; c++) begin @(posedge clk); #1; end
        check("pre_rst_err_nonzero", 32'(err_count != 16'h0), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_idle("mid_rst");
        dc = 0;
        for (int c = 0; c < RUN_CYC + 10; c++) begin
            @(posedge clk); #1;
            if (done) dc++;
        end
        check("mid_rst_no_done", 32'(dc), 32'd0);
        do_run("after_rst", 0, 1'b0);

        f_op  = 4'($urandom_range(0, 8));
        f_bit = 5'($urandom_range(0, 31));
        do_run("flip_fault_hold", 3, 1'b1);
        start = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_idle("final_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
